run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter MAX_CYCLES, default 16'd1000, run-cycle limit before forced stop.
REQ-002 CLK  in  1  clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Go  in  1  host run request; level-held for the whole four-phase handshake.
REQ-005 Prog_Sel  in  2  program select, sampled in IDLE on the cycle Go is first seen high.
REQ-006 Halt_Req  in  1  halt instruction decoded by the core; single-cycle or level.
REQ-007 Start  out  1  one-cycle load pulse to the fetch unit.
REQ-008 Start_Addr  out  8  start address presented to the fetch unit.
REQ-009 Halt  out  1  freezes the fetch unit's PC.
REQ-010 Busy  out  1  high in LAUNCH and RUN.
REQ-011 Done  out  1  high in DONE state.
REQ-012 Timeout  out  1  high in DONE when the run ended by the cycle limit.
REQ-013 Cycle_Count  out  16  run cycles of the current or last run.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, RUN and DONE.
REQ-015 IDLE: Halt=1, Start=0, Busy=0, Done=0; Go=1 -> LAUNCH, latch Prog_Sel, clear Cycle_Count and Timeout.
REQ-016 Start_Addr SHALL equal the package table entry START_ADDR[latched Prog_Sel], stable from LAUNCH until the next launch.
REQ-017 LAUNCH lasts exactly one cycle: Start=1, Halt=0, then unconditional -> RUN.
REQ-018 RUN: Halt=0, Start=0; Cycle_Count increments by 1 each cycle, saturating at 16'hFFFF.
REQ-019 RUN with Halt_Req=1 -> DONE, Timeout=0; the halting cycle is counted.
REQ-020 RUN with Cycle_Count==MAX_CYCLES-1 and Halt_Req=0 -> DONE, Timeout=1.
REQ-021 Halt_Req and timeout in the same cycle: Halt_Req wins, Timeout=0.
REQ-022 RUN with Go=0 (abort) -> IDLE directly; Done never asserts; Cycle_Count keeps its value.
REQ-023 Abort takes priority over Halt_Req and timeout in the same cycle.
REQ-024 DONE: Halt=1, Done=1, Cycle_Count and Timeout frozen; Go=0 -> IDLE.
REQ-025 Go held high through DONE SHALL NOT relaunch; a new run needs Go low for at least one cycle.
REQ-026 Halt_Req SHALL be ignored outside RUN.
REQ-027 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
REQ-028 Reset SHALL have priority over all other inputs and place the FSM in IDLE.
REQ-029 After reset: Halt=1, Start=0, Busy=0, Done=0, Timeout=0, Cycle_Count=0, latched Prog_Sel=0, Start_Addr=START_ADDR[0].
REQ-030 Reset asserted in LAUNCH or RUN SHALL abort the run within the same edge; no Start pulse follows.

Structure
REQ-031 Package run_pkg SHALL hold the state enum (IDLE, LAUNCH, RUN, DONE) and the START_ADDR table {8'h00, 8'h40, 8'h80, 8'hC0}.
REQ-032 One sub-module, sat_counter (16-bit, clear/enable, saturating), SHALL implement Cycle_Count; the FSM lives in run_ctrl.

Verification
REQ-033 Reset mid-RUN -> next cycle IDLE, Halt=1, Cycle_Count=0, no Start.
REQ-034 Prog_Sel=2, Go=1 in IDLE -> one-cycle Start with Start_Addr=8'h80; Halt_Req on the 5th RUN cycle -> Done=1, Cycle_Count=5, Timeout=0.
REQ-035 MAX_CYCLES=8, no Halt_Req -> Done=1, Timeout=1, Cycle_Count=8 after 8 RUN cycles.
REQ-036 MAX_CYCLES=8, Halt_Req on the 8th RUN cycle -> Timeout=0, Cycle_Count=8.
REQ-037 Go dropped on the 3rd RUN cycle with Halt_Req=1 -> IDLE, Done never high, Cycle_Count=2.
REQ-038 Go held high 4 cycles in DONE, then low 1 cycle, then high with Prog_Sel=1 -> exactly one new Start, Start_Addr=8'h40.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM state encoding and
// the per-program start address table.
package run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } state_e;

    localparam logic [7:0] START_ADDR [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};

endpackage

// File: rtl/run_ctrl_if.sv
// Host/core-side signal bundle of the run controller; slave is the controller,
// master is the host/core driving run requests and halts.
interface run_ctrl_if;

    logic        Go;
    logic [1:0]  Prog_Sel;
    logic        Halt_Req;
    logic        Start;
    logic [7:0]  Start_Addr;
    logic        Halt;
    logic        Busy;
    logic        Done;
    logic        Timeout;
    logic [15:0] Cycle_Count;

    modport slave (
        input  Go, Prog_Sel, Halt_Req,
        output Start, Start_Addr, Halt, Busy, Done, Timeout, Cycle_Count
    );

    modport master (
        output Go, Prog_Sel, Halt_Req,
        input  Start, Start_Addr, Halt, Busy, Done, Timeout, Cycle_Count
    );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// 16-bit up-counter with synchronous clear and enable; holds at all-ones
// instead of wrapping.
module sat_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: launches a program at its table start address, counts run
// cycles and stops on halt, cycle limit or host abort.
module run_ctrl
    import run_pkg::*;
#(
    parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
    input  logic        CLK,
    input  logic        Reset,
    run_ctrl_if.slave   bus
);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        timeout_q, timeout_d;
    logic        cnt_clr, cnt_en;
    logic [15:0] count;

    sat_counter u_cycle_cnt (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (count)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    // Abort outranks halt, which outranks the cycle limit.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Go) begin
                    state_d   = LAUNCH;
                    sel_d     = bus.Prog_Sel;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (!bus.Go) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (bus.Halt_Req) begin
                        state_d   = DONE;
                        timeout_d = 1'b0;
                    end else if (count == MAX_CYCLES - 16'd1) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!bus.Go) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Start       = (state_q == LAUNCH);
    assign bus.Halt        = (state_q == IDLE) || (state_q == DONE);
    assign bus.Busy        = (state_q == LAUNCH) || (state_q == RUN);
    assign bus.Done        = (state_q == DONE);
    assign bus.Timeout     = timeout_q && (state_q == DONE);
    assign bus.Start_Addr  = START_ADDR[sel_q];
    assign bus.Cycle_Count = count;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized runs
// scored against a cycle-outcome model of halt/limit/abort precedence.
module tb_run_ctrl;

    localparam int MAXC = 8;
    localparam int K_ABORT = 0;
    localparam int K_HALT = 1;
    localparam int K_TOUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [7:0] tbl [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};

    run_ctrl_if bus ();

    run_ctrl #(.MAX_CYCLES(16'(MAXC))) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Outcome of a run: first RUN cycle k (1-based) where abort, halt or the
    // limit applies, in that order of precedence; h/a of 0 mean "never".
    function automatic void predict(input int h, input int a, input int m,
                                    output int kend, output int kind, output int cnt);
        kend = m; kind = K_TOUT; cnt = m;
        for (int k = 1; k <= m; k++) begin
            if (k == a) begin
                kend = k; kind = K_ABORT; cnt = k - 1; return;
            end else if (k == h) begin
                kend = k; kind = K_HALT; cnt = k; return;
            end
        end
    endfunction

    task automatic do_run(input int ps, input int h, input int a, input string tag);
        int kend, kind, cnt;
        predict(h, a, MAXC, kend, kind, cnt);
        bus.Go = 1'b1;
        bus.Prog_Sel = 2'(ps);
        bus.Halt_Req = 1'($urandom_range(0, 1));
        step;
        vecs++;
        if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b1100 ||
            bus.Start_Addr !== tbl[ps] || bus.Cycle_Count !== 16'd0) begin
            errs++;
            $display("FAIL %s launch: SBHD=%b addr=%h cnt=%0d, want 1100 addr=%h cnt=0",
                     tag, {bus.Start, bus.Busy, bus.Halt, bus.Done}, bus.Start_Addr,
                     bus.Cycle_Count, tbl[ps]);
        end
        bus.Prog_Sel = 2'($urandom);
        bus.Halt_Req = 1'b0;
        step;
        for (int k = 1; k <= kend; k++) begin
            vecs++;
            if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b0100 ||
                bus.Cycle_Count !== 16'(k - 1) || bus.Start_Addr !== tbl[ps]) begin
                errs++;
                $display("FAIL %s run%0d: SBHD=%b cnt=%0d addr=%h, want 0100 cnt=%0d addr=%h",
                         tag, k, {bus.Start, bus.Busy, bus.Halt, bus.Done},
                         bus.Cycle_Count, bus.Start_Addr, k - 1, tbl[ps]);
            end
            bus.Go = (k == a) ? 1'b0 : 1'b1;
            bus.Halt_Req = (k == h) ? 1'b1 : 1'b0;
            step;
        end
        bus.Halt_Req = 1'b0;
        vecs++;
        if (kind == K_ABORT) begin
            if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b0010 ||
                bus.Cycle_Count !== 16'(cnt)) begin
                errs++;
                $display("FAIL %s abort_end: SBHD=%b cnt=%0d, want 0010 cnt=%0d",
                         tag, {bus.Start, bus.Busy, bus.Halt, bus.Done}, bus.Cycle_Count, cnt);
            end
        end else begin
            if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b0011 ||
                bus.Cycle_Count !== 16'(cnt) || bus.Timeout !== (kind == K_TOUT)) begin
                errs++;
                $display("FAIL %s done_end: SBHD=%b cnt=%0d to=%b, want 0011 cnt=%0d to=%b",
                         tag, {bus.Start, bus.Busy, bus.Halt, bus.Done}, bus.Cycle_Count,
                         bus.Timeout, cnt, kind == K_TOUT);
            end
        end
    endtask

    task automatic to_idle(input logic [15:0] cnt, input string tag);
        bus.Go = 1'b0;
        bus.Halt_Req = 1'($urandom_range(0, 1));
        step;
        bus.Halt_Req = 1'b0;
        vecs++;
        if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b0010 || bus.Cycle_Count !== cnt) begin
            errs++;
            $display("FAIL %s idle: SBHD=%b cnt=%0d, want 0010 cnt=%0d",
                     tag, {bus.Start, bus.Busy, bus.Halt, bus.Done}, bus.Cycle_Count, cnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.Go = 1'b1;
        bus.Prog_Sel = 2'd3;
        bus.Halt_Req = 1'b1;
        step;
        step;
        vecs++;
        if ({bus.Start, bus.Busy, bus.Halt, bus.Done, bus.Timeout} !== 5'b00100 ||
            bus.Cycle_Count !== 16'd0 || bus.Start_Addr !== 8'h00) begin
            errs++;
            $display("FAIL reset: SBHDT=%b cnt=%0d addr=%h, want 00100 cnt=0 addr=00",
                     {bus.Start, bus.Busy, bus.Halt, bus.Done, bus.Timeout},
                     bus.Cycle_Count, bus.Start_Addr);
        end
        bus.Go = 1'b0;
        rst = 1'b0;
        step;
        vecs++;
        if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b0010) begin
            errs++;
            $display("FAIL idle_halt_ignored: SBHD=%b, want 0010",
                     {bus.Start, bus.Busy, bus.Halt, bus.Done});
        end
        bus.Halt_Req = 1'b0;
    endtask

    task automatic test_halt_5th;
        do_run(2, 5, 0, "halt5");
        to_idle(16'd5, "halt5");
    endtask

    task automatic test_timeout;
        do_run(1, 0, 0, "timeout");
        to_idle(16'd8, "timeout");
    endtask

    task automatic test_halt_at_limit;
        do_run(3, 8, 0, "halt_at_limit");
        to_idle(16'd8, "halt_at_limit");
    endtask

    task automatic test_abort;
        do_run(0, 3, 3, "abort");
    endtask

    task automatic test_reset_mid_run;
        bus.Go = 1'b1;
        bus.Prog_Sel = 2'd3;
        step;
        step;
        step;
        step;
        rst = 1'b1;
        bus.Go = 1'b0;
        step;
        vecs++;
        if ({bus.Start, bus.Busy, bus.Halt, bus.Done} !== 4'b0010 ||
            bus.Cycle_Count !== 16'd0 || bus.Start_Addr !== 8'h00) begin
            errs++;
            $display("FAIL reset_run: SBHD=%b cnt=%0d addr=%h, want 0010 cnt=0 addr=00",
                     {bus.Start, bus.Busy, bus.Halt, bus.Done}, bus.Cycle_Count, bus.Start_Addr);
        end
        rst = 1'b0;
        bus.Go = 1'b1;
        bus.Prog_Sel = 2'd2;
        step;
        rst = 1'b1;
        bus.Go = 1'b0;
        step;
        rst = 1'b0;
        step;
        vecs++;
        if (bus.Start !== 1'b0 || bus.Busy !== 1'b0 || bus.Start_Addr !== 8'h00) begin
            errs++;
            $display("FAIL reset_launch: start=%b busy=%b addr=%h, want 0 0 00",
                     bus.Start, bus.Busy, bus.Start_Addr);
        end
    endtask

    task automatic test_relaunch;
        int starts;
        do_run(0, 3, 0, "relaunch");
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            bus.Go = 1'b1;
            bus.Halt_Req = 1'($urandom_range(0, 1));
            step;
            if (bus.Start === 1'b1) starts++;
            vecs++;
            if (bus.Done !== 1'b1 || bus.Cycle_Count !== 16'd3) begin
                errs++;
                $display("FAIL done_hold%0d: done=%b cnt=%0d, want 1 3", i, bus.Done, bus.Cycle_Count);
            end
        end
        bus.Halt_Req = 1'b0;
        to_idle(16'd3, "relaunch");
        bus.Go = 1'b1;
        bus.Prog_Sel = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step;
            if (bus.Start === 1'b1) starts++;
        end
        vecs++;
        if (starts != 1 || bus.Start_Addr !== 8'h40) begin
            errs++;
            $display("FAIL relaunch_start: starts=%0d addr=%h, want 1 40", starts, bus.Start_Addr);
        end
        bus.Go = 1'b0;
        step;
    endtask

    task automatic test_random;
        int ps, h, a, kend, kind, cnt;
        for (int n = 0; n < 40; n++) begin
            ps = $urandom_range(0, 3);
            h = $urandom_range(0, 10);
            a = $urandom_range(0, 12);
            predict(h, a, MAXC, kend, kind, cnt);
            do_run(ps, h, a, "random");
            if (kind != K_ABORT) to_idle(16'(cnt), "random");
        end
    endtask

    initial begin
        bus.Go = 1'b0;
        bus.Prog_Sel = 2'd0;
        bus.Halt_Req = 1'b0;
        test_reset;
        test_halt_5th;
        test_timeout;
        test_halt_at_limit;
        test_abort;
        test_reset_mid_run;
        test_relaunch;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
